// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: busy scoreboard, RF read port drive, registered operand bundle.
// Optional OPFETCH_BYPASS_EN forwards a same-cycle writeback into a blocked source operand.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_use_rs,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic              in_wb,
  input  logic [ADDR_W-1:0] in_rd,
  output logic [1:0]        rf_read_en,
  output logic [ADDR_W-1:0] rf_raddr_0,
  output logic [ADDR_W-1:0] rf_raddr_1,
  input  logic [DATA_W-1:0] rf_rdata_0,
  input  logic [DATA_W-1:0] rf_rdata_1,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic              out_wb,
  output logic [ADDR_W-1:0] out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0]       state;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             hit0;
  logic             hit1;
  logic             slot_free;
  logic             hazard;
  logic             accept;

`ifdef OPFETCH_BYPASS_EN
  assign hit0 = wb_valid && (wb_addr == in_rs0);
  assign hit1 = wb_valid && (wb_addr == in_rs1);
`else
  assign hit0 = 1'b0;
  assign hit1 = 1'b0;
`endif

  // Writeback passes straight through; the RF commits it on the next edge.
  assign rf_write_en = wb_valid;
  assign rf_waddr    = wb_addr;
  assign rf_wdata    = wb_data;
  assign rf_raddr_0  = in_rs0;
  assign rf_raddr_1  = in_rs1;

  always_comb begin
    slot_free  = !out_valid || out_ready;
    // The destination check has no bypass: a pending write to rd always stalls (WAW).
    hazard     = (in_use_rs[0] && busy[in_rs0] && !hit0)
              || (in_use_rs[1] && busy[in_rs1] && !hit1)
              || (in_wb && busy[in_rd]);
    in_ready   = slot_free && !hazard;
    accept     = in_valid && in_ready;
    rf_read_en = (in_valid && slot_free) ? in_use_rs : 2'b00;
  end

  // Clear on writeback first so a same-edge dispatch to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)
      busy_nxt[wb_addr] = 1'b0;
    if (accept && in_wb)
      busy_nxt[in_rd] = 1'b1;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_op0   <= '0;
      out_op1   <= '0;
      out_wb    <= 1'b0;
      out_rd    <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_op0   <= !in_use_rs[0] ? '0 : (hit0 ? wb_data : rf_rdata_0);
        out_op1   <= !in_use_rs[1] ? '0 : (hit1 ? wb_data : rf_rdata_1);
        out_wb    <= in_wb;
        out_rd    <= in_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      if (state == ST_STALL && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        ST_RUN:   if (in_valid && slot_free && hazard) state <= ST_STALL;
        ST_STALL: if (!hazard || !in_valid)            state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; a small RF model sits on the rf_* ports.
// Expectations follow the OPFETCH_BYPASS_EN setting used for the build.
module tb_operand_fetch;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_use_rs;
  logic [ADDR_W-1:0] in_rs0, in_rs1, in_rd;
  logic              in_wb;
  logic [1:0]        rf_read_en;
  logic [ADDR_W-1:0] rf_raddr_0, rf_raddr_1, rf_waddr;
  logic [DATA_W-1:0] rf_rdata_0, rf_rdata_1, rf_wdata;
  logic              rf_write_en;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready, out_wb;
  logic [DATA_W-1:0] out_op0, out_op1;
  logic [ADDR_W-1:0] out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  logic [DATA_W-1:0] rf_mem [NREGS];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_use_rs(in_use_rs),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_wb(in_wb), .in_rd(in_rd),
    .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
    .out_wb(out_wb), .out_rd(out_rd), .stall_cnt(stall_cnt)
  );

  // Register file model: combinational read, write on the rising edge.
  assign rf_rdata_0 = rf_mem[rf_raddr_0];
  assign rf_rdata_1 = rf_mem[rf_raddr_1];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_waddr] <= rf_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_use_rs = 2'b00; in_rs0 = '0; in_rs1 = '0;
    in_wb = 1'b0; in_rd = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'h100 + i;
    idle();
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_op0", out_op0, 0);
    check("rst_out_rd", out_rd, 0);
    tick(); tick();
    reset_n = 1'b1;

    // 1: writeback r5 then read it back.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("wb_pass_en", rf_write_en, 1);
    check("wb_pass_addr", rf_waddr, 5);
    check("wb_pass_data", rf_wdata, 32'hDEADBEEF);
    tick();
    idle();
    in_valid = 1'b1; in_use_rs = 2'b01; in_rs0 = 5'd5;
    #1;
    check("t1_in_ready", in_ready, 1);
    check("t1_read_en", rf_read_en, 2'b01);
    tick();
    idle();
    check("t1_out_valid", out_valid, 1);
    check("t1_op0", out_op0, 32'hDEADBEEF);
    check("t1_op1_unused", out_op1, 0);
    tick();
    check("t1_drain", out_valid, 0);

    // 2: RAW hazard on r3.
    in_valid = 1'b1; in_wb = 1'b1; in_rd = 5'd3;
    tick();
    idle();
    in_valid = 1'b1; in_use_rs = 2'b10; in_rs1 = 5'd3;
    #1;
    check("t2_raw_ready", in_ready, 0);
    tick();
    check("t2_cnt_first", stall_cnt, 0);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
    #1;
`ifdef OPFETCH_BYPASS_EN
    check("t2_bypass_ready", in_ready, 1);
    tick();
    exp_cnt = 1;
`else
    check("t2_nobyp_ready", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("t2_cnt_mid", stall_cnt, 1);
    check("t2_after_wb_ready", in_ready, 1);
    tick();
    exp_cnt = 2;
`endif
    idle();
    check("t2_out_valid", out_valid, 1);
    check("t2_op1", out_op1, 32'h1234);
    check("t2_op0_unused", out_op0, 0);
    check("t2_stall_cnt", stall_cnt, exp_cnt);
    tick();

    // 3: backpressure holds the bundle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_use_rs = 2'b01; in_rs0 = 5'd5;
    tick();
    in_rs0 = 5'd3;
    #1;
    check("t3_held_ready", in_ready, 0);
    check("t3_held_read_en", rf_read_en, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_held_op0", out_op0, 32'hDEADBEEF);
      check("t3_held_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", in_ready, 1);
    tick();
    check("t3_next_op0", out_op0, 32'h1234);
    in_rs0 = 5'd5;
    tick();
    check("t3_b2b_op0", out_op0, 32'hDEADBEEF);
    check("t3_b2b_valid", out_valid, 1);
    idle();
    tick();
    check("t3_drain", out_valid, 0);

    // 4: same-edge writeback clear and dispatch set on r7.
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    in_valid = 1'b1; in_wb = 1'b1; in_rd = 5'd7;
    #1;
    check("t4_ready", in_ready, 1);
    tick();
    idle();
    check("t4_out_rd", out_rd, 7);
    check("t4_out_wb", out_wb, 1);
    in_valid = 1'b1; in_use_rs = 2'b01; in_rs0 = 5'd7;
    #1;
    check("t4_busy7_ready", in_ready, 0);
    idle();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick();
    idle();
    check("t4_cnt_kept", stall_cnt, exp_cnt);

    // 5: async reset mid-cycle with busy[2] set and a held bundle.
    in_valid = 1'b1; in_wb = 1'b1; in_rd = 5'd2;
    tick();
    idle();
    out_ready = 1'b0;
    #1;
    check("t5_pre_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_cnt", stall_cnt, 0);
    check("t5_rst_rd", out_rd, 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_use_rs = 2'b01; in_rs0 = 5'd2;
    #1;
    check("t5_r2_ready", in_ready, 1);
    tick();
    idle();
    check("t5_op0", out_op0, 32'h102);

    // 6: long stall saturates the counter.
    in_valid = 1'b1; in_wb = 1'b1; in_rd = 5'd9;
    tick();
    idle();
    in_valid = 1'b1; in_use_rs = 2'b01; in_rs0 = 5'd9;
    repeat (5) tick();
    check("t6_cnt_4", stall_cnt, 4);
    repeat ((1 << CNT_W) - 1) tick();
    check("t6_cnt_sat", stall_cnt, 16'hFFFF);
    tick();
    check("t6_cnt_hold", stall_cnt, 16'hFFFF);
    check("t6_still_blocked", in_ready, 0);
    idle();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    tick();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
